register_file: RTL and testbench

32-entry integer register file for the single-cycle RV32I core, sitting between decode and the halt checker. It provides two combinational read ports for the datapath and one synchronous write port from writeback. A dedicated always-valid tap of x17 feeds the halt checker, so an `ecall` decoded in a cycle is judged against x17's current architectural value. x0 is hardwired to zero, and the stack and global pointers come out of reset at fixed values.

---
 rtl/register_file_pkg.sv | 16 +
 rtl/register_file.sv | 64 ++++++
 tb/tb_register_file.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared constants for the RV32I register file: reset values of sp/gp and the
// architectural indices the core top, halt checker and bench agree on.
package register_file_pkg;

  localparam int unsigned        XLEN_DEF    = 32;
  localparam logic [31:0]        SP_INIT_DEF = 32'h0000_2ffc;
  localparam logic [31:0]        GP_INIT_DEF = 32'h0000_1800;

  localparam logic [4:0]         ZERO_IDX    = 5'd0;
  localparam logic [4:0]         SP_IDX      = 5'd2;
  localparam logic [4:0]         GP_IDX      = 5'd3;
  localparam logic [4:0]         X17_IDX     = 5'd17;

  localparam int unsigned        NUM_REGS    = 32;

endpackage

// File: rtl/register_file.sv
// 32-entry RV32I integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero and an always-valid x17 tap.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned       XLEN    = XLEN_DEF,
  parameter logic [XLEN-1:0]   SP_INIT = XLEN'(SP_INIT_DEF),
  parameter logic [XLEN-1:0]   GP_INIT = XLEN'(GP_INIT_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rd_din,
  input  logic            write_enable,
  output logic [XLEN-1:0] rs1_dout,
  output logic [XLEN-1:0] rs2_dout,
  output logic [XLEN-1:0] x17_dout
);

  // x0 has no storage; entries 1..31 only.
  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0] regs_d [1:NUM_REGS-1];

  function automatic logic [XLEN-1:0] reset_value(input logic [4:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (idx == SP_IDX) val = SP_INIT;
    if (idx == GP_IDX) val = GP_INIT;
    return val;
  endfunction

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx,
                                                input logic [XLEN-1:0] val);
    return (idx == ZERO_IDX) ? '0 : val;
  endfunction

  // Reset dominates any write presented on the same edge.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_d[i] = reset_value(5'(i));
      end
    end else if (write_enable && (rd != ZERO_IDX)) begin
      regs_d[rd] = rd_din;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // No write-to-read bypass: reads always see the committed state.
  assign rs1_dout = read_port(rs1, regs_q[(rs1 == ZERO_IDX) ? 5'd1 : rs1]);
  assign rs2_dout = read_port(rs2, regs_q[(rs2 == ZERO_IDX) ? 5'd1 : rs2]);
  assign x17_dout = regs_q[X17_IDX];

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file with hand-computed expectations.
module tb_register_file;
  import register_file_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_din;
  logic            write_enable;
  logic [XLEN-1:0] rs1_dout;
  logic [XLEN-1:0] rs2_dout;
  logic [XLEN-1:0] x17_dout;

  int vec_cnt;
  int err_cnt;

  register_file dut (
    .clk          (clk),
    .reset        (reset),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .rd_din       (rd_din),
    .write_enable (write_enable),
    .rs1_dout     (rs1_dout),
    .rs2_dout     (rs2_dout),
    .x17_dout     (x17_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1ns past it before touching inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rst_val(input int idx);
    if (idx == 2) return 32'h0000_2ffc;
    if (idx == 3) return 32'h0000_1800;
    return 32'h0;
  endfunction

  logic [XLEN-1:0] model [0:31];
  logic            halted;

  initial begin
    vec_cnt      = 0;
    err_cnt      = 0;
    reset        = 1'b1;
    rs1          = '0;
    rs2          = '0;
    rd           = '0;
    rd_din       = '0;
    write_enable = 1'b0;
    halted       = 1'b0;

    // Reset then idle
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rs1_x%0d", i), rs1_dout, rst_val(i));
      chk($sformatf("rst_rs2_x%0d", 31 - i), rs2_dout, rst_val(31 - i));
    end
    chk("rst_x17_tap", x17_dout, 32'h0);

    // Write x5 and read back; old value visible before the edge
    rd = 5'd5; rd_din = 32'hdeadbeef; write_enable = 1'b1;
    rs1 = 5'd5; rs2 = 5'd5;
    #1;
    chk("wr_x5_pre_rs1", rs1_dout, 32'h0);
    chk("wr_x5_pre_rs2", rs2_dout, 32'h0);
    tick();
    write_enable = 1'b0;
    #1;
    chk("wr_x5_post_rs1", rs1_dout, 32'hdeadbeef);
    chk("wr_x5_post_rs2", rs2_dout, 32'hdeadbeef);

    // x0 writes are discarded, over several cycles
    rd = 5'd0; rd_din = 32'hffffffff; write_enable = 1'b1;
    rs1 = 5'd0; rs2 = 5'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("x0_rs1_c%0d", c), rs1_dout, 32'h0);
      chk($sformatf("x0_x1_c%0d", c), rs2_dout, 32'h0);
    end
    write_enable = 1'b0;
    tick();
    chk("x0_after", rs1_dout, 32'h0);

    // x17 tap: li a7,10 then ecall in the next cycle, then a7=11
    rd = X17_IDX; rd_din = 32'd10; write_enable = 1'b1;
    #1;
    chk("x17_pre", x17_dout, 32'h0);
    tick();
    chk("x17_eq10", x17_dout, 32'd10);
    if (x17_dout == 32'd10) halted = 1'b1;
    rd_din = 32'd11;
    tick();
    write_enable = 1'b0;
    chk("x17_eq11", x17_dout, 32'd11);
    chk("halt_seen", {31'b0, halted}, 32'h1);
    rs1 = 5'd17;
    #1;
    chk("x17_rs1", rs1_dout, 32'd11);

    // Write disabled
    rd = 5'd7; rd_din = 32'h1234; write_enable = 1'b0; rs1 = 5'd7;
    tick();
    chk("wen0_x7", rs1_dout, 32'h0);

    // Reset vs write collision
    rd = 5'd9; rd_din = 32'h55; write_enable = 1'b1; rs1 = 5'd9;
    tick();
    chk("coll_x9_commit", rs1_dout, 32'h55);
    reset = 1'b1; rd_din = 32'haa;
    tick();
    reset = 1'b0; write_enable = 1'b0;
    rs1 = 5'd9; rs2 = 5'd2;
    #1;
    chk("coll_x9", rs1_dout, 32'h0);
    chk("coll_x2", rs2_dout, 32'h0000_2ffc);
    rs1 = 5'd3; rs2 = 5'd5;
    #1;
    chk("coll_x3", rs1_dout, 32'h0000_1800);
    chk("coll_x5", rs2_dout, 32'h0);
    chk("coll_x17", x17_dout, 32'h0);

    // Fill every register with a distinct pattern, then read back all
    write_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd     = 5'(i);
      rd_din = 32'(i) * 32'h0101_0101 ^ 32'ha5a5_0000;
      model[i] = (i == 0) ? 32'h0 : rd_din;
      tick();
    end
    write_enable = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(i);
      #1;
      chk($sformatf("fill_rs1_x%0d", i), rs1_dout, model[i]);
      chk($sformatf("fill_rs2_x%0d", i), rs2_dout, model[i]);
    end
    chk("fill_x17_tap", x17_dout, model[17]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
